// File: rtl/gdu_rect_fill.sv
// Rectangle-fill graphics drawing unit: Avalon-MM register file and command FIFO feeding a
// word-packing framebuffer rasteriser. Define GDU_STALL_CNT_EN to add the register 6 stall counter.
module gdu_rect_fill #(
    parameter logic [31:0] FB_BASE   = 32'h0800_0000,
    parameter int          FB_WIDTH  = 640,
    parameter int          FB_HEIGHT = 480,
    parameter int          BPP       = 16,
    parameter int          CMD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] avalon_mm_master_address,
    output logic [3:0]  avalon_mm_master_byteenable,
    input  logic        avalon_mm_master_waitrequest,
    output logic        avalon_mm_master_write,
    output logic [31:0] avalon_mm_master_writedata,
    input  logic [9:0]  avalon_mm_slave_address,
    input  logic [3:0]  avalon_mm_slave_byteenable,
    input  logic        avalon_mm_slave_read,
    output logic [31:0] avalon_mm_slave_readdata,
    input  logic        avalon_mm_slave_write,
    input  logic [31:0] avalon_mm_slave_writedata
);

    localparam int PPW        = 32 / BPP;
    localparam int LANE_BYTES = BPP / 8;
    localparam int PPW_SHIFT  = $clog2(PPW);
    localparam int PTR_W      = $clog2(CMD_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int CMD_W      = 40 + BPP;
    localparam logic [31:0]      FB_W    = 32'(FB_WIDTH);
    localparam logic [31:0]      FB_H    = 32'(FB_HEIGHT);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CMD_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        NEXT  = 2'd3
    } state_t;

    function automatic logic [31:0] replicate_color(input logic [BPP-1:0] c);
        logic [31:0] r;
        r = 32'd0;
        for (int l = 0; l < PPW; l++) begin
            r[l*BPP +: BPP] = c;
        end
        return r;
    endfunction

    // A lane is enabled when its linear pixel index lies inside the current row span [pf, pl].
    function automatic logic [3:0] lane_mask(input logic [31:0] word, input logic [31:0] pf,
                                             input logic [31:0] pl);
        logic [3:0]  m;
        logic [31:0] p;
        m = 4'd0;
        for (int l = 0; l < PPW; l++) begin
            p = (word << PPW_SHIFT) + 32'(l);
            if ((p >= pf) && (p <= pl)) begin
                m[l*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{1'b1}};
            end else begin
                m[l*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{1'b0}};
            end
        end
        return m;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [9:0]         reg_x0_r, reg_y0_r, reg_w_r, reg_h_r;
    logic [BPP-1:0]     reg_color_r;
    logic               overflow_r;
    logic [31:0]        readdata_r;
    logic [CMD_W-1:0]   fifo_mem_r [CMD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   fifo_cnt_r;
    logic [9:0]         cur_x0_r, cur_y0_r, cur_w_r, cur_h_r;
    logic [BPP-1:0]     cur_color_r;
    logic [31:0]        row_r, word_r, last_word_r, pfirst_r, plast_r;
    logic               master_write_r;
    logic [31:0]        master_address_r, master_writedata_r;
    logic [3:0]         master_byteenable_r;

    logic               go_s, clr_s, full_s, fifo_empty_s, pop_s, push_s, busy_s;
    logic [CMD_W-1:0]   cmd_in_s, head_s;
    logic [31:0]        status_s, rd_mux_s;
    logic [31:0]        x_end_sum_s, y_end_sum_s, xe_s, ye_s, row_sel_s, pf_s, pl_s, word_s;
    logic               cmd_empty_s, new_span_s, row_done_s, load_out_s, unused_s;

    assign go_s         = avalon_mm_slave_write && (avalon_mm_slave_address == 10'd3);
    assign clr_s        = avalon_mm_slave_write && (avalon_mm_slave_address == 10'd5);
    assign full_s       = (fifo_cnt_r == DEPTH_C);
    assign fifo_empty_s = (fifo_cnt_r == {CNT_W{1'b0}});
    assign pop_s        = (state_r == IDLE) && !fifo_empty_s;
    assign push_s       = go_s && (!full_s || pop_s);
    assign busy_s       = (state_r != IDLE) || !fifo_empty_s;
    assign cmd_in_s     = {reg_x0_r, reg_y0_r, reg_w_r, reg_h_r, reg_color_r};
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign unused_s     = ^{avalon_mm_slave_byteenable, avalon_mm_slave_writedata};

    assign avalon_mm_master_write       = master_write_r;
    assign avalon_mm_master_address     = master_address_r;
    assign avalon_mm_master_byteenable  = master_byteenable_r;
    assign avalon_mm_master_writedata   = master_writedata_r;
    assign avalon_mm_slave_readdata     = readdata_r;

    // Host-visible shadow registers; GO snapshots them, so later writes never touch a queued command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_x0_r    <= 10'd0;
            reg_y0_r    <= 10'd0;
            reg_w_r     <= 10'd0;
            reg_h_r     <= 10'd0;
            reg_color_r <= {BPP{1'b0}};
        end else if (avalon_mm_slave_write) begin
            case (avalon_mm_slave_address)
                10'd0: begin
                    reg_x0_r <= avalon_mm_slave_writedata[9:0];
                    reg_y0_r <= avalon_mm_slave_writedata[25:16];
                end
                10'd1: begin
                    reg_w_r <= avalon_mm_slave_writedata[9:0];
                    reg_h_r <= avalon_mm_slave_writedata[25:16];
                end
                10'd2:   reg_color_r <= avalon_mm_slave_writedata[BPP-1:0];
                default: reg_color_r <= reg_color_r;
            endcase
        end
    end

    // Sticky overflow; a GO dropped in the same cycle as CLR still leaves the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (go_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_s) begin
            overflow_r <= 1'b0;
        end
    end

`ifdef GDU_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of master cycles spent stalled by waitrequest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'd0;
        end else if (avalon_mm_slave_write && (avalon_mm_slave_address == 10'd6)) begin
            stall_cnt_r <= 32'd0;
        end else if (master_write_r && avalon_mm_master_waitrequest && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end
`endif

    // Status word and read-data selection.
    always_comb begin
        status_s       = 32'd0;
        status_s[0]    = busy_s;
        status_s[1]    = full_s;
        status_s[15:8] = 8'(fifo_cnt_r);
        status_s[16]   = overflow_r;
        rd_mux_s       = 32'd0;
        case (avalon_mm_slave_address)
            10'd0:   rd_mux_s = {6'd0, reg_y0_r, 6'd0, reg_x0_r};
            10'd1:   rd_mux_s = {6'd0, reg_h_r, 6'd0, reg_w_r};
            10'd2:   rd_mux_s = 32'(reg_color_r);
            10'd4:   rd_mux_s = status_s;
`ifdef GDU_STALL_CNT_EN
            10'd6:   rd_mux_s = stall_cnt_r;
`endif
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Registered slave read data, updated only when a read is sampled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata_r <= 32'd0;
        end else if (avalon_mm_slave_read) begin
            readdata_r <= rd_mux_s;
        end
    end

    // Command FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= cmd_in_s;
        end
    end

    // Command FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            fifo_cnt_r <= fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Clip bounds and next word / row span, evaluated in LOAD (first row) and NEXT (advance).
    always_comb begin
        x_end_sum_s = {22'd0, cur_x0_r} + {22'd0, cur_w_r};
        y_end_sum_s = {22'd0, cur_y0_r} + {22'd0, cur_h_r};
        xe_s        = (x_end_sum_s > FB_W) ? FB_W : x_end_sum_s;
        ye_s        = (y_end_sum_s > FB_H) ? FB_H : y_end_sum_s;
        cmd_empty_s = (cur_w_r == 10'd0) || (cur_h_r == 10'd0) ||
                      ({22'd0, cur_x0_r} >= FB_W) || ({22'd0, cur_y0_r} >= FB_H);
        row_sel_s   = (state_r == LOAD) ? {22'd0, cur_y0_r} : (row_r + 32'd1);
        new_span_s  = (state_r == LOAD) || (word_r == last_word_r);
        row_done_s  = (row_r + 32'd1) >= ye_s;
        pf_s        = pfirst_r;
        pl_s        = plast_r;
        word_s      = word_r + 32'd1;
        if (new_span_s) begin
            pf_s   = row_sel_s * FB_W + {22'd0, cur_x0_r};
            pl_s   = row_sel_s * FB_W + xe_s - 32'd1;
            word_s = pf_s >> PPW_SHIFT;
        end
    end

    // Rasteriser state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Rasteriser next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = fifo_empty_s ? IDLE : LOAD;
            LOAD:    state_nxt_s = cmd_empty_s ? IDLE : WRITE;
            WRITE:   state_nxt_s = avalon_mm_master_waitrequest ? WRITE : NEXT;
            NEXT:    state_nxt_s = ((word_r == last_word_r) && row_done_s) ? IDLE : WRITE;
            default: state_nxt_s = IDLE;
        endcase
        load_out_s = (state_nxt_s == WRITE) && (state_r != WRITE);
    end

    // In-flight command and raster position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_x0_r    <= 10'd0;
            cur_y0_r    <= 10'd0;
            cur_w_r     <= 10'd0;
            cur_h_r     <= 10'd0;
            cur_color_r <= {BPP{1'b0}};
            row_r       <= 32'd0;
            word_r      <= 32'd0;
            last_word_r <= 32'd0;
            pfirst_r    <= 32'd0;
            plast_r     <= 32'd0;
        end else begin
            if (pop_s) begin
                cur_x0_r    <= head_s[BPP+39 -: 10];
                cur_y0_r    <= head_s[BPP+29 -: 10];
                cur_w_r     <= head_s[BPP+19 -: 10];
                cur_h_r     <= head_s[BPP+9 -: 10];
                cur_color_r <= head_s[BPP-1:0];
            end
            if ((state_r == LOAD) || (state_r == NEXT)) begin
                word_r      <= word_s;
                pfirst_r    <= pf_s;
                plast_r     <= pl_s;
                last_word_r <= pl_s >> PPW_SHIFT;
                if (new_span_s) row_r <= row_sel_s;
            end
        end
    end

    // Master outputs are loaded on entry to WRITE and held until waitrequest releases the transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            master_write_r      <= 1'b0;
            master_address_r    <= 32'd0;
            master_byteenable_r <= 4'd0;
            master_writedata_r  <= 32'd0;
        end else if (load_out_s) begin
            master_write_r      <= 1'b1;
            master_address_r    <= FB_BASE + (word_s << 2);
            master_byteenable_r <= lane_mask(word_s, pf_s, pl_s);
            master_writedata_r  <= replicate_color(cur_color_r);
        end else if ((state_r == WRITE) && !avalon_mm_master_waitrequest) begin
            master_write_r      <= 1'b0;
            master_address_r    <= 32'd0;
            master_byteenable_r <= 4'd0;
            master_writedata_r  <= 32'd0;
        end
    end

endmodule

// File: tb/tb_gdu_rect_fill.sv
// Self-checking bench for gdu_rect_fill (default parameters) with a pixel-level framebuffer write model.
module tb_gdu_rect_fill;

    localparam int          FB_W = 640;
    localparam int          FB_H = 480;
    localparam int          BPP  = 16;
    localparam int          PPW  = 32 / BPP;
    localparam int          LB   = BPP / 8;
    localparam logic [31:0] BASE = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] m_addr, m_wdata, s_rdata;
    logic [3:0]  m_be;
    logic        m_wait = 1'b0, m_write;
    logic [9:0]  s_addr = 10'd0;
    logic [3:0]  s_be = 4'hF;
    logic        s_read = 1'b0, s_write = 1'b0;
    logic [31:0] s_wdata = 32'd0;
    logic        rand_wait_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] obs_addr[$], obs_data[$], exp_addr[$], exp_data[$];
    logic [3:0]  obs_be[$], exp_be[$];

    gdu_rect_fill dut (
        .clk                          (clk),
        .reset                        (reset),
        .avalon_mm_master_address     (m_addr),
        .avalon_mm_master_byteenable  (m_be),
        .avalon_mm_master_waitrequest (m_wait),
        .avalon_mm_master_write       (m_write),
        .avalon_mm_master_writedata   (m_wdata),
        .avalon_mm_slave_address      (s_addr),
        .avalon_mm_slave_byteenable   (s_be),
        .avalon_mm_slave_read         (s_read),
        .avalon_mm_slave_readdata     (s_rdata),
        .avalon_mm_slave_write        (s_write),
        .avalon_mm_slave_writedata    (s_wdata)
    );

    always #5 clk = ~clk;

    // Record every accepted master write; waitrequest only changes just after a rising edge.
    always @(negedge clk) begin
        if (reset && m_write && !m_wait) begin
            obs_addr.push_back(m_addr);
            obs_be.push_back(m_be);
            obs_data.push_back(m_wdata);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_wait_en) m_wait = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic slave_write(input logic [9:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        s_addr = a; s_wdata = d; s_write = 1'b1;
        @(posedge clk); #1;
        s_write = 1'b0;
    endtask

    task automatic slave_read(input logic [9:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        s_addr = a; s_read = 1'b1;
        @(posedge clk); #1;
        s_read = 1'b0;
        d = s_rdata;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        logic [31:0] st;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            slave_read(10'd4, st);
            if (st[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic issue_cmd(input int x0, input int y0, input int w, input int h, input logic [31:0] col);
        slave_write(10'd0, {6'd0, 10'(y0), 6'd0, 10'(x0)});
        slave_write(10'd1, {6'd0, 10'(h), 6'd0, 10'(w)});
        slave_write(10'd2, col);
        slave_write(10'd3, 32'd1);
    endtask

    // Pixel-by-pixel reference: visit every clipped pixel and merge lanes landing in the same word of a row.
    task automatic model_cmd(input int x0, input int y0, input int w, input int h, input logic [31:0] col);
        int xe, ye, p, wd, last_wd;
        logic [31:0] data;
        logic [3:0]  lb;
        if (w == 0 || h == 0 || x0 >= FB_W || y0 >= FB_H) return;
        xe = (x0 + w > FB_W) ? FB_W : x0 + w;
        ye = (y0 + h > FB_H) ? FB_H : y0 + h;
        for (int l = 0; l < PPW; l++) data[l*BPP +: BPP] = col[BPP-1:0];
        for (int y = y0; y < ye; y++) begin
            last_wd = -1;
            for (int x = x0; x < xe; x++) begin
                p  = y * FB_W + x;
                wd = p / PPW;
                lb = 4'(((1 << LB) - 1) << ((p % PPW) * LB));
                if (wd == last_wd) begin
                    exp_be[exp_be.size()-1] = exp_be[exp_be.size()-1] | lb;
                end else begin
                    exp_addr.push_back(BASE + 32'(wd) * 32'd4);
                    exp_be.push_back(lb);
                    exp_data.push_back(data);
                    last_wd = wd;
                end
            end
        end
    endtask

    task automatic clear_queues();
        obs_addr.delete(); obs_be.delete(); obs_data.delete();
        exp_addr.delete(); exp_be.delete(); exp_data.delete();
    endtask

    task automatic test_reset();
        logic [31:0] st;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({m_write, m_addr, m_be, m_wdata, s_rdata} !== 101'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got write=%0b addr=%h be=%b data=%h rdata=%h, want all 0",
                     m_write, m_addr, m_be, m_wdata, s_rdata);
        end
        slave_read(10'd4, st);
        n_checks++;
        if (st !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_status: got %h want 00000000", st);
        end
    endtask

    task automatic test_basic();
        logic [31:0] st;
        bit ok;
        clear_queues();
        issue_cmd(1, 2, 3, 1, 32'h0000_F800);
        slave_read(10'd4, st);
        n_checks++;
        if (st[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got busy=%0b want 1", st[0]);
        end
        wait_idle(200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_idle: busy still 1 after budget, want 0");
        end
        n_checks++;
        if (obs_addr.size() != 2) begin
            n_fail++;
            $display("FAIL basic_count: got %0d writes want 2", obs_addr.size());
        end else begin
            n_checks++;
            if (obs_addr[0] !== 32'h0800_0A00 || obs_be[0] !== 4'b1100 || obs_data[0] !== 32'hF800_F800) begin
                n_fail++;
                $display("FAIL basic_w0: got %h/%b/%h want 08000a00/1100/f800f800", obs_addr[0], obs_be[0], obs_data[0]);
            end
            n_checks++;
            if (obs_addr[1] !== 32'h0800_0A04 || obs_be[1] !== 4'b1111 || obs_data[1] !== 32'hF800_F800) begin
                n_fail++;
                $display("FAIL basic_w1: got %h/%b/%h want 08000a04/1111/f800f800", obs_addr[1], obs_be[1], obs_data[1]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a0, d0, st, cnt, want_cnt;
        logic [3:0]  b0;
        bit ok, seen;
        clear_queues();
        slave_write(10'd6, 32'd0);
        m_wait = 1'b1;
        issue_cmd(1, 2, 3, 1, 32'h0000_F800);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (m_write) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL stall_start: got write=0 want 1 within 50 cycles");
        end
        a0 = m_addr; b0 = m_be; d0 = m_wdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (m_write !== 1'b1 || m_addr !== 32'h0800_0A00 || m_be !== 4'b1100 || m_wdata !== 32'hF800_F800 ||
                m_addr !== a0 || m_be !== b0 || m_wdata !== d0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %0b/%h/%b/%h want 1/08000a00/1100/f800f800", i, m_write, m_addr, m_be, m_wdata);
            end
            @(posedge clk); #1;
        end
        m_wait = 1'b0;
        wait_idle(200, ok);
        n_checks++;
        if (!ok || obs_addr.size() != 2) begin
            n_fail++;
            $display("FAIL stall_writes: got %0d writes idle=%0b want 2 idle=1", obs_addr.size(), ok);
        end else begin
            n_checks++;
            if (obs_addr[0] !== 32'h0800_0A00 || obs_addr[1] !== 32'h0800_0A04) begin
                n_fail++;
                $display("FAIL stall_order: got %h,%h want 08000a00,08000a04", obs_addr[0], obs_addr[1]);
            end
        end
`ifdef GDU_STALL_CNT_EN
        want_cnt = 32'd5;
`else
        want_cnt = 32'd0;
`endif
        slave_read(10'd6, cnt);
        n_checks++;
        if (cnt !== want_cnt) begin
            n_fail++;
            $display("FAIL stall_counter: got %0d want %0d", cnt, want_cnt);
        end
        slave_read(10'd4, st);
        n_checks++;
        if (st !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_status: got %h want 00000000", st);
        end
    endtask

    task automatic test_clip();
        bit ok;
        clear_queues();
        issue_cmd(638, 479, 10, 10, 32'h0000_1234);
        wait_idle(200, ok);
        n_checks++;
        if (!ok || obs_addr.size() != 1) begin
            n_fail++;
            $display("FAIL clip_count: got %0d writes idle=%0b want 1 idle=1", obs_addr.size(), ok);
        end else begin
            n_checks++;
            if (obs_addr[0] !== 32'h0809_5FFC || obs_be[0] !== 4'b1111 || obs_data[0] !== 32'h1234_1234) begin
                n_fail++;
                $display("FAIL clip_w0: got %h/%b/%h want 08095ffc/1111/12341234", obs_addr[0], obs_be[0], obs_data[0]);
            end
        end
    endtask

    task automatic test_empty();
        logic [31:0] st;
        bit ok;
        clear_queues();
        issue_cmd(5, 5, 0, 3, 32'h0000_00FF);
        issue_cmd(700, 5, 4, 3, 32'h0000_00FF);
        issue_cmd(5, 480, 4, 3, 32'h0000_00FF);
        wait_idle(200, ok);
        slave_read(10'd4, st);
        n_checks++;
        if (!ok || st !== 32'd0) begin
            n_fail++;
            $display("FAIL empty_status: got %h idle=%0b want 00000000 idle=1", st, ok);
        end
        n_checks++;
        if (obs_addr.size() != 0) begin
            n_fail++;
            $display("FAIL empty_writes: got %0d writes want 0", obs_addr.size());
        end
    endtask

    task automatic test_overflow();
        logic [31:0] st;
        bit ok;
        clear_queues();
        m_wait = 1'b1;
        slave_write(10'd0, {6'd0, 10'd2, 6'd0, 10'd1});
        slave_write(10'd1, {6'd0, 10'd1, 6'd0, 10'd3});
        slave_write(10'd2, 32'h0000_F800);
        for (int i = 0; i < 6; i++) slave_write(10'd3, 32'd1);
        slave_read(10'd4, st);
        n_checks++;
        if (st !== 32'h0001_0403) begin
            n_fail++;
            $display("FAIL overflow_status: got %h want 00010403", st);
        end
        slave_write(10'd5, 32'd0);
        slave_read(10'd4, st);
        n_checks++;
        if (st !== 32'h0000_0403) begin
            n_fail++;
            $display("FAIL overflow_clear: got %h want 00000403", st);
        end
        m_wait = 1'b0;
        wait_idle(500, ok);
        n_checks++;
        if (!ok || obs_addr.size() != 10) begin
            n_fail++;
            $display("FAIL overflow_drain: got %0d writes idle=%0b want 10 idle=1", obs_addr.size(), ok);
        end
    endtask

    task automatic test_random();
        int x0, y0, w, h, ncmd;
        logic [31:0] col;
        bit ok;
        for (int b = 0; b < 8; b++) begin
            clear_queues();
            rand_wait_en = 1'b1;
            ncmd = $urandom_range(1, 3);
            for (int c = 0; c < ncmd; c++) begin
                x0  = ($urandom_range(0, 3) == 0) ? 620 + $urandom_range(0, 100) : $urandom_range(0, 639);
                y0  = ($urandom_range(0, 3) == 0) ? 470 + $urandom_range(0, 20) : $urandom_range(0, 479);
                w   = $urandom_range(0, 24);
                h   = $urandom_range(0, 4);
                col = $urandom;
                model_cmd(x0, y0, w, h, col);
                issue_cmd(x0, y0, w, h, col);
            end
            wait_idle(3000, ok);
            rand_wait_en = 1'b0;
            @(posedge clk); #1 m_wait = 1'b0;
            n_checks++;
            if (!ok || obs_addr.size() != exp_addr.size()) begin
                n_fail++;
                $display("FAIL random_count[%0d]: got %0d writes idle=%0b want %0d idle=1", b, obs_addr.size(), ok, exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
                n_checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_be[i] !== exp_be[i] || obs_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL random_write[%0d.%0d]: got %h/%b/%h want %h/%b/%h", b, i,
                             obs_addr[i], obs_be[i], obs_data[i], exp_addr[i], exp_be[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] st;
        bit seen;
        clear_queues();
        m_wait = 1'b0;
        issue_cmd(0, 0, 4, 4, 32'h0000_07E0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (obs_addr.size() >= 2 && m_write) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_mid_row1: got no row-1 write within 100 cycles, want one");
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (m_write !== 1'b0 || m_be !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got write=%0b be=%b want 0/0000", m_write, m_be);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        n_checks++;
        if (obs_addr.size() != 2) begin
            n_fail++;
            $display("FAIL reset_mid_partial: got %0d writes before reset want 2", obs_addr.size());
        end
        repeat (30) @(posedge clk);
        slave_read(10'd4, st);
        n_checks++;
        if (st !== 32'd0 || obs_addr.size() != 2) begin
            n_fail++;
            $display("FAIL reset_mid_after: got status=%h writes=%0d want 00000000 and 2", st, obs_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_clip();
        test_empty();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
